// File: rtl/imm_pkg.sv
// Shared RV32I immediate/format definitions used by the instruction encoder
// and the immediate generator.
package imm_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned F7_W      = 7;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [SEL_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_JAL     = 3'd4,
    FMT_JALR    = 3'd5,
    FMT_U       = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_sel_e;

  typedef struct packed {
    fmt_sel_e               sel;
    logic [OPC_W-1:0]       opcode;
    logic [REG_W-1:0]       rd;
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [F3_W-1:0]        funct3;
    logic [F7_W-1:0]        funct7;
    logic [XLEN-1:0]        imm;
  } inst_fields_t;

  // True when v[XLEN-1:lsb] are all copies of the same bit (fits as signed).
  function automatic logic upper_sign_ok(input logic [XLEN-1:0] v,
                                         input int unsigned     lsb);
    logic [XLEN-1:0] sh;
    sh = XLEN'($signed(v) >>> lsb);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer with immediate range checking; a failed
// check replaces the word with a NOP.
module inst_pack
  import imm_pkg::*;
(
  input  inst_fields_t    fields,
  output logic [XLEN-1:0] inst_c,
  output logic            err_c
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] raw;
  logic            bad;

  assign imm = fields.imm;

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (fields.sel)
      FMT_R: begin
        raw = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
               fields.rd, fields.opcode};
      end
      FMT_I, FMT_JALR: begin
        raw = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        bad = !upper_sign_ok(imm, 11);
      end
      FMT_S: begin
        raw = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
               imm[4:0], fields.opcode};
        bad = !upper_sign_ok(imm, 11);
      end
      FMT_B: begin
        raw = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
               imm[4:1], imm[11], fields.opcode};
        bad = !upper_sign_ok(imm, 12) || imm[0];
      end
      FMT_JAL: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd,
               fields.opcode};
        bad = !upper_sign_ok(imm, 20) || imm[0];
      end
      FMT_U: begin
        raw = {imm[31:12], fields.rd, fields.opcode};
        bad = (imm[11:0] != 12'd0);
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  assign inst_c = bad ? NOP_INST : raw;
  assign err_c  = bad;

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into a word,
// tags it with an auto-incrementing byte address and counts errored words.
module inst_encoder
  import imm_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic [OPC_W-1:0]     i_opcode,
  input  logic [REG_W-1:0]     i_rd,
  input  logic [REG_W-1:0]     i_rs1,
  input  logic [REG_W-1:0]     i_rs2,
  input  logic [F3_W-1:0]      i_funct3,
  input  logic [F7_W-1:0]      i_funct7,
  input  logic [XLEN-1:0]      i_imm,
  input  logic                 i_restart,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [XLEN-1:0]      o_inst,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [ADDR_W-1:0]    ADDR_STEP   = ADDR_W'(4);
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  inst_fields_t      fields;
  logic [XLEN-1:0]   inst_c;
  logic              err_c;
  logic              accept;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] take_addr;

  assign fields = '{
    sel:    fmt_sel_e'(i_sel),
    opcode: i_opcode,
    rd:     i_rd,
    rs1:    i_rs1,
    rs2:    i_rs2,
    funct3: i_funct3,
    funct7: i_funct7,
    imm:    i_imm
  };

  inst_pack u_pack (
    .fields (fields),
    .inst_c (inst_c),
    .err_c  (err_c)
  );

  // Output slot frees up when empty or being drained this cycle.
  assign o_ready   = !o_valid || i_out_ready;
  assign accept    = i_valid && o_ready;
  assign take_addr = i_restart ? BASE_ADDR : addr_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_inst  <= '0;
      o_addr  <= BASE_ADDR;
      o_err   <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_inst  <= inst_c;
      o_addr  <= take_addr;
      o_err   <= err_c;
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Restart and accept in the same cycle: the word takes BASE_ADDR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_cnt <= BASE_ADDR;
    end else if (accept) begin
      addr_cnt <= take_addr + ADDR_STEP;
    end else if (i_restart) begin
      addr_cnt <= BASE_ADDR;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (accept && err_c && (o_err_cnt != ERR_CNT_MAX)) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed, table-driven bench for inst_encoder with hand-sequenced
// backpressure, restart and reset corner cases.
module tb_inst_encoder;
  import imm_pkg::*;

  localparam int unsigned       ADDR_W = 32;
  localparam logic [ADDR_W-1:0] BASE   = 32'h0000_1000;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [2:0]        i_sel = '0;
  logic [6:0]        i_opcode = '0;
  logic [4:0]        i_rd = '0;
  logic [4:0]        i_rs1 = '0;
  logic [4:0]        i_rs2 = '0;
  logic [2:0]        i_funct3 = '0;
  logic [6:0]        i_funct7 = '0;
  logic [31:0]       i_imm = '0;
  logic              i_restart = 1'b0;
  logic              o_valid;
  logic              i_out_ready = 1'b1;
  logic [31:0]       o_inst;
  logic [ADDR_W-1:0] o_addr;
  logic              o_err;
  logic [7:0]        o_err_cnt;

  always #5 i_clk = ~i_clk;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sel       (i_sel),
    .i_opcode    (i_opcode),
    .i_rd        (i_rd),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_funct3    (i_funct3),
    .i_funct7    (i_funct7),
    .i_imm       (i_imm),
    .i_restart   (i_restart),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_inst      (o_inst),
    .o_addr      (o_addr),
    .o_err       (o_err),
    .o_err_cnt   (o_err_cnt)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_addr;
  int          exp_cnt;
  vec_t        vecs[$];

  function automatic vec_t mk(input logic [2:0] sel, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_inst, input logic exp_err);
    vec_t v;
    v.sel = sel; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = exp_inst; v.exp_err = exp_err;
    return v;
  endfunction

  // Immediate-generator decode used to round-trip encoded words.
  function automatic logic [31:0] dec_imm(input logic [2:0] sel, input logic [31:0] w);
    case (sel)
      3'd1:    return {{20{w[31]}}, w[31:20]};
      3'd3:    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_sel = v.sel; i_opcode = v.op; i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2;
    i_funct3 = v.f3; i_funct7 = v.f7; i_imm = v.imm;
  endtask

  // One accepted word with i_out_ready=1, checked one cycle later.
  task automatic send(input vec_t v, input string tag);
    drive(v);
    i_valid = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_restart = 1'b0;
    if (v.exp_err && exp_cnt < 255) exp_cnt++;
    chk({tag, " valid"}, 32'(o_valid), 32'd1);
    chk({tag, " inst"}, o_inst, v.exp_inst);
    chk({tag, " err"}, 32'(o_err), 32'(v.exp_err));
    chk({tag, " addr"}, o_addr, exp_addr);
    chk({tag, " err_cnt"}, 32'(o_err_cnt), 32'(exp_cnt));
    exp_addr = exp_addr + 32'd4;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " valid"}, 32'(o_valid), 32'd0);
    chk({tag, " inst"}, o_inst, 32'd0);
    chk({tag, " addr"}, o_addr, BASE);
    chk({tag, " err"}, 32'(o_err), 32'd0);
    chk({tag, " err_cnt"}, 32'(o_err_cnt), 32'd0);
    chk({tag, " ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got_addr[$];
    logic [31:0] got_inst[$];
    logic [31:0] bp_inst[4];
    vec_t        w;
    int          sent;
    logic        acc;
    logic        tk;

    vecs.push_back(mk(3'd1, 7'h13, 5'd5,  5'd6, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0));
    vecs.push_back(mk(3'd6, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_5537, 1'b0));
    vecs.push_back(mk(3'd6, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0008, 32'h0080_00EF, 1'b0));
    vecs.push_back(mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2049,      32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd7, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0));
    vecs.push_back(mk(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0));
    vecs.push_back(mk(3'd2, 7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFF8, 32'hFE20_AC23, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 1'b0));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_F000, 32'h8020_8063, 1'b0));
    vecs.push_back(mk(3'd5, 7'h67, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_8067, 1'b0));
    vecs.push_back(mk(3'd5, 7'h67, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 32'h0010_8067, 1'b0));
    vecs.push_back(mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk(3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0));
    vecs.push_back(mk(3'd6, 7'h37, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F0B7, 1'b0));
    vecs.push_back(mk(3'd2, 7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0800, 32'h0000_0013, 1'b1));

    bp_inst[0] = 32'h0010_0093;
    bp_inst[1] = 32'h0020_0113;
    bp_inst[2] = 32'h0030_0193;
    bp_inst[3] = 32'h0040_0213;

    exp_addr = BASE;
    exp_cnt  = 0;

    repeat (2) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (vecs[k]) begin
      send(vecs[k], $sformatf("vec%0d", k));
      if (!vecs[k].exp_err && (vecs[k].sel == 3'd1 || vecs[k].sel == 3'd3 || vecs[k].sel == 3'd4))
        chk($sformatf("vec%0d roundtrip", k), dec_imm(vecs[k].sel, o_inst), vecs[k].imm);
    end

    // Error counter saturation.
    w = mk(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0000_0013, 1'b1);
    for (int n = 0; n < 300; n++) send(w, "sat");
    chk("sat final", 32'(o_err_cnt), 32'd255);

    // Drain, then stream 4 words with a 3-cycle stall after the first.
    @(posedge i_clk);
    #1;
    chk("drain valid", 32'(o_valid), 32'd0);
    sent = 0;
    for (int cyc = 0; cyc < 40 && got_addr.size() < 4; cyc++) begin
      if (sent < 4) begin
        w = mk(3'd1, 7'h13, 5'(sent + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(sent + 1), 32'h0, 1'b0);
        drive(w);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      i_restart   = (cyc == 0);
      i_out_ready = !(cyc >= 1 && cyc <= 3);
      @(negedge i_clk);
      if (cyc >= 1 && cyc <= 3) begin
        chk("bp ready low", 32'(o_ready), 32'd0);
        chk("bp hold valid", 32'(o_valid), 32'd1);
        chk("bp hold inst", o_inst, bp_inst[0]);
        chk("bp hold addr", o_addr, BASE);
      end
      acc = i_valid && o_ready;
      tk  = o_valid && i_out_ready;
      if (tk) begin
        got_addr.push_back(o_addr);
        got_inst.push_back(o_inst);
      end
      @(posedge i_clk);
      #1;
      if (acc) sent++;
    end
    i_valid = 1'b0;
    i_restart = 1'b0;
    i_out_ready = 1'b1;
    chk("bp count", 32'(got_addr.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
      chk($sformatf("bp addr%0d", k), got_addr[k], BASE + 32'(4 * k));
      chk($sformatf("bp inst%0d", k), got_inst[k], bp_inst[k]);
    end
    @(posedge i_clk);
    #1;

    // Restart coincident with an accept; error count survives restart.
    exp_addr = BASE;
    i_restart = 1'b1;
    send(vecs[0], "restart0");
    send(vecs[1], "restart1");

    // Reset while a word is held.
    i_out_ready = 1'b0;
    drive(vecs[2]);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("pre-reset valid", 32'(o_valid), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_values("mid reset");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post-reset no word", 32'(o_valid), 32'd0);
    exp_addr = BASE;
    exp_cnt  = 0;
    send(vecs[2], "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
